iter_divider: RTL and testbench
===============================

ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter SIGNED, default 1, meaning: 1 = two's-complement divide (div), 0 = unsigned divide (divu).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have s_axis_dividend_tdata  input  32  dividend.
REQ-005 SHALL have s_axis_dividend_tvalid  input  1  dividend valid.
REQ-006 SHALL have s_axis_dividend_tready  output  1  dividend accepted when high with tvalid.
REQ-007 SHALL have s_axis_divisor_tdata  input  32  divisor.
REQ-008 SHALL have s_axis_divisor_tvalid  input  1  divisor valid.
REQ-009 SHALL have s_axis_divisor_tready  output  1  divisor accepted when high with tvalid.
REQ-010 SHALL have m_axis_dout_tdata  output  64  result {quotient[63:32], remainder[31:0]}.
REQ-011 SHALL have m_axis_dout_tvalid  output  1  one-cycle result-valid pulse; no backpressure input.

Function
REQ-012 SHALL implement FSM states IDLE, PREP, ITER, FIX, DONE.
REQ-013 SHALL drive both tready outputs identically: high only in IDLE.
REQ-014 SHALL accept an operation only on a cycle where state is IDLE and both tvalid inputs are high; one tvalid alone SHALL be ignored, nothing captured.
REQ-015 SHALL, on accept, register both operands and go to PREP.
REQ-016 PREP: SHALL form magnitudes (SIGNED=1: absolute values; SIGNED=0: raw), latch quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend); go to ITER with 6-bit step counter = 0.
REQ-017 ITER: SHALL perform one restoring radix-2 step per cycle on a 33-bit partial remainder, 32 cycles (counter 0..31), then go to FIX.
REQ-018 FIX: SHALL apply latched signs (negate quotient and/or remainder in two's complement) when SIGNED=1; go to DONE.
REQ-019 DONE: SHALL assert m_axis_dout_tvalid for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be fixed: accept at cycle T -> m_axis_dout_tvalid high at cycle T+35, operand-independent.
REQ-021 m_axis_dout_tdata SHALL be updated only on entry to DONE and held stable until the next DONE.
REQ-022 Divisor = 0: quotient SHALL be 32'hFFFFFFFF, remainder SHALL be the raw dividend, regardless of SIGNED; latency unchanged.
REQ-023 SIGNED=1, 32'h80000000 / 32'hFFFFFFFF: quotient 32'h80000000, remainder 0 (wraps, no error flag).
REQ-024 tvalid held high through DONE SHALL be accepted in the IDLE cycle following DONE (back-to-back throughput one op per 36 cycles).
REQ-025 Input changes while not in IDLE SHALL have no effect on the operation in flight.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, m_axis_dout_tvalid 0, m_axis_dout_tdata 64'h0, both tready 0 during the reset cycle.
REQ-027 Reset mid-operation SHALL abort with no dout_tvalid pulse; tready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-028 Shared package SHALL hold: FSM state encoding, DIV_W = 32, DIV_STEPS = 32, DIV_LATENCY = 35.
REQ-029 SHALL instantiate one combinational sub-module div_iter_step (33-bit trial subtract, next remainder, quotient bit).

Verification
REQ-030 SIGNED=1, 7 / -2 (32'hFFFFFFFE) -> dout = {32'hFFFFFFFD, 32'h00000001} exactly 35 cycles after accept.
REQ-031 SIGNED=1, -7 / 2 -> {32'hFFFFFFFD, 32'hFFFFFFFF}; SIGNED=0, 32'hFFFFFFFF / 32'h10 -> {32'h0FFFFFFF, 32'h0000000F}.
REQ-032 Divide by zero: 5 / 0 -> {32'hFFFFFFFF, 32'h00000005}; SIGNED=1, 32'h80000000 / 32'hFFFFFFFF -> {32'h80000000, 0}.
REQ-033 Handshake: dividend_tvalid high 10 cycles with divisor_tvalid low -> no accept, tready stays 1; then divisor_tvalid high -> accept that cycle, tready 0 next cycle.
REQ-034 Back-to-back: both tvalid held high with 100/7 then 9/3 -> dout_tvalid pulses 36 cycles apart with {14, 2} then {3, 0}, each pulse exactly one cycle.
REQ-035 Reset asserted 10 cycles after accept -> no dout_tvalid pulse, dout_tdata 0, tready 1 on the first post-reset cycle; new 6/4 -> {1, 2}.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
// Holds the FSM state encoding and the datapath width/step/latency figures.
package iter_divider_pkg;

  localparam int DIV_W       = 32;
  localparam int DIV_STEPS   = 32;
  localparam int DIV_LATENCY = 35;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_t;

  function automatic logic [DIV_W-1:0] twos_neg(input logic [DIV_W-1:0] v);
    return (~v) + {{(DIV_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Operand and result streams of the divider, bundled for port connection.
// The slave side is the divider; the master side is whoever feeds it.
interface iter_divider_if;
  import iter_divider_pkg::*;

  logic [DIV_W-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [DIV_W-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*DIV_W-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid
  );

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid
  );
endinterface

// File: rtl/div_iter_step.sv
// One restoring radix-2 division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_iter_step
  import iter_divider_pkg::*;
(
  input  logic [DIV_W:0]   rem_in,
  input  logic [DIV_W-1:0] quo_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W:0]   rem_out,
  output logic [DIV_W-1:0] quo_out
);
  logic [DIV_W:0] shifted;
  logic [DIV_W:0] diff;
  logic           q_bit;

  // rem_in < divisor always holds, so the borrow shows up in the top bit of diff.
  assign shifted = {rem_in[DIV_W-1:0], quo_in[DIV_W-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[DIV_W];
  assign rem_out = q_bit ? diff : shifted;
  assign quo_out = {quo_in[DIV_W-2:0], q_bit};

endmodule

// File: rtl/iter_divider.sv
// Fixed-latency iterative divider (signed or unsigned by parameter).
// Quotient lives in the dividend shift register as bits shift out.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  iter_divider_if.slave bus
);
  div_state_t state, state_next;

  logic [DIV_W-1:0]   dividend_r, divisor_r, div_mag, quo_q, quo_step;
  logic [DIV_W:0]     rem_q, rem_step;
  logic [5:0]         step_cnt;
  logic               q_neg, r_neg;
  logic [2*DIV_W-1:0] dout_r;
  logic               accept, last_step;
  logic [DIV_W-1:0]   quo_fix, rem_fix;

  assign accept    = (state == ST_IDLE) && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;
  assign last_step = (step_cnt == 6'(DIV_STEPS - 1));

  assign bus.s_axis_dividend_tready = (state == ST_IDLE) && !reset;
  assign bus.s_axis_divisor_tready  = (state == ST_IDLE) && !reset;
  assign bus.m_axis_dout_tvalid     = (state == ST_DONE);
  assign bus.m_axis_dout_tdata      = dout_r;

  div_iter_step u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_mag),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  assign quo_fix = q_neg ? twos_neg(quo_q) : quo_q;
  assign rem_fix = r_neg ? twos_neg(rem_q[DIV_W-1:0]) : rem_q[DIV_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_PREP;
      ST_PREP: state_next = ST_ITER;
      ST_ITER: if (last_step) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_r <= '0;
      divisor_r  <= '0;
      div_mag    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      step_cnt   <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dout_r     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            dividend_r <= bus.s_axis_dividend_tdata;
            divisor_r  <= bus.s_axis_divisor_tdata;
          end
        end
        ST_PREP: begin
          div_mag  <= (SIGNED && divisor_r[DIV_W-1])  ? twos_neg(divisor_r)  : divisor_r;
          quo_q    <= (SIGNED && dividend_r[DIV_W-1]) ? twos_neg(dividend_r) : dividend_r;
          rem_q    <= '0;
          step_cnt <= '0;
          q_neg    <= SIGNED && (dividend_r[DIV_W-1] ^ divisor_r[DIV_W-1]);
          r_neg    <= SIGNED && dividend_r[DIV_W-1];
        end
        ST_ITER: begin
          rem_q    <= rem_step;
          quo_q    <= quo_step;
          step_cnt <= step_cnt + 6'd1;
        end
        ST_FIX: begin
          // Divide-by-zero bypasses sign fix-up so the dividend comes back untouched.
          if (divisor_r == '0) dout_r <= {{DIV_W{1'b1}}, dividend_r};
          else                 dout_r <= {quo_fix, rem_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: one signed and one unsigned instance,
// directed vectors with hand-computed results, latency and pulse-width checks.
module tb_iter_divider;
  import iter_divider_pkg::*;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
    string       name;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] dvd [2];
  logic [31:0] dvs [2];
  logic        vd  [2];
  logic        vs  [2];
  logic        rdy_a [2];
  logic        rdy_b [2];
  logic        ov  [2];
  logic [63:0] od  [2];
  logic        prev_ov [2];
  int          pulse_cyc [2];
  int          prev_pulse_cyc [2];

  sb_t q0 [$];
  sb_t q1 [$];

  iter_divider_if bus_s ();
  iter_divider_if bus_u ();

  iter_divider #(.SIGNED(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bus_s.slave));
  iter_divider #(.SIGNED(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(bus_u.slave));

  assign bus_s.s_axis_dividend_tdata  = dvd[0];
  assign bus_s.s_axis_divisor_tdata   = dvs[0];
  assign bus_s.s_axis_dividend_tvalid = vd[0];
  assign bus_s.s_axis_divisor_tvalid  = vs[0];
  assign bus_u.s_axis_dividend_tdata  = dvd[1];
  assign bus_u.s_axis_divisor_tdata   = dvs[1];
  assign bus_u.s_axis_dividend_tvalid = vd[1];
  assign bus_u.s_axis_divisor_tvalid  = vs[1];
  assign rdy_a[0] = bus_s.s_axis_dividend_tready;
  assign rdy_b[0] = bus_s.s_axis_divisor_tready;
  assign rdy_a[1] = bus_u.s_axis_dividend_tready;
  assign rdy_b[1] = bus_u.s_axis_divisor_tready;
  assign ov[0] = bus_s.m_axis_dout_tvalid;
  assign ov[1] = bus_u.m_axis_dout_tvalid;
  assign od[0] = bus_s.m_axis_dout_tdata;
  assign od[1] = bus_u.m_axis_dout_tdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int ch, input logic [63:0] exp, input string nm, input int c);
    sb_t e;
    e.exp = exp; e.cyc = c; e.name = nm;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic on_pulse(input int ch);
    sb_t e;
    bit  have;
    have = 1'b0;
    if (ch == 0 && q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
    if (ch == 1 && q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
    if (!have) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_pulse ch%0d: got dout %h expected no pulse (cycle %0d)", ch, od[ch], cyc);
    end else begin
      check(e.name, od[ch], e.exp);
      check({e.name, "_latency"}, 64'(cyc - e.cyc), 64'(DIV_LATENCY));
    end
  endtask

  // Monitors: one per instance, sampling on the falling edge.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (ov[ch] === 1'b1) begin
        if (prev_ov[ch] === 1'b1) begin
          n_vec++; n_err++;
          $display("FAIL pulse_width ch%0d: got tvalid 1 on consecutive cycles expected single cycle", ch);
        end
        on_pulse(ch);
        prev_pulse_cyc[ch] = pulse_cyc[ch];
        pulse_cyc[ch] = cyc;
      end
      prev_ov[ch] = ov[ch];
    end
  end

  task automatic issue(input int ch, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string nm, input bit push, input bit hold);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    dvd[ch] = a; dvs[ch] = b; vd[ch] = 1'b1; vs[ch] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rdy_a[ch] && rdy_b[ch]) got = 1'b1;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s_accept: got no accept expected accept within 200 cycles", nm);
    end else if (push) begin
      push_exp(ch, exp, nm, cyc);
    end
    if (!hold) begin
      @(posedge clk); #1;
      vd[ch] = 1'b0; vs[ch] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      dvd[ch] = '0; dvs[ch] = '0; vd[ch] = 1'b0; vs[ch] = 1'b0;
      prev_ov[ch] = 1'b0; pulse_cyc[ch] = 0; prev_pulse_cyc[ch] = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tready_a", 64'(rdy_a[0]), 64'd0);
    check("reset_tready_b", 64'(rdy_b[0]), 64'd0);
    check("reset_tvalid",   64'(ov[0]), 64'd0);
    check("reset_tdata",    od[0], 64'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_tready", 64'(rdy_a[0] & rdy_b[0]), 64'd1);

    fork
      begin
        issue(0, 32'd7,        32'hFFFFFFFE, {32'hFFFFFFFD, 32'h00000001}, "s_7_div_m2",   1, 0);
        issue(0, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFD, 32'hFFFFFFFF}, "s_m7_div_2",   1, 0);
        issue(0, 32'd5,        32'd0,        {32'hFFFFFFFF, 32'h00000005}, "s_5_div_0",    1, 0);
        issue(0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}, "s_min_div_m1", 1, 0);
        issue(0, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFFF, 32'hFFFFFFF9}, "s_m7_div_0",   1, 0);
        issue(0, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'h0000000E, 32'hFFFFFFFE}, "s_m100_div_m7",1, 0);
        issue(0, 32'd0,        32'd3,        {32'h00000000, 32'h00000000}, "s_0_div_3",    1, 0);
      end
      begin
        issue(1, 32'hFFFFFFFF, 32'h10,       {32'h0FFFFFFF, 32'h0000000F}, "u_max_div_16", 1, 0);
        issue(1, 32'd5,        32'd0,        {32'hFFFFFFFF, 32'h00000005}, "u_5_div_0",    1, 0);
        issue(1, 32'hFFFFFFFE, 32'hFFFFFFFF, {32'h00000000, 32'hFFFFFFFE}, "u_big_div",    1, 0);
        issue(1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, "u_min_div_max",1, 0);
      end
    join
    drain();

    // Handshake: dividend alone must not be taken.
    @(posedge clk); #1;
    dvd[0] = 32'd21; dvs[0] = 32'd4; vd[0] = 1'b1; vs[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hs_lone_valid_tready", 64'(rdy_a[0] & rdy_b[0]), 64'd1);
    end
    @(posedge clk); #1 vs[0] = 1'b1;
    @(negedge clk);
    check("hs_accept_tready", 64'(rdy_a[0] & rdy_b[0]), 64'd1);
    push_exp(0, {32'd5, 32'd1}, "hs_21_div_4", cyc);
    @(posedge clk); #1 vd[0] = 1'b0; vs[0] = 1'b0;
    @(negedge clk);
    check("hs_busy_tready", 64'(rdy_a[0] | rdy_b[0]), 64'd0);
    drain();

    // Back-to-back with valids held; data changed mid-flight must be ignored.
    issue(0, 32'd100, 32'd7, {32'd14, 32'd2}, "b2b_100_div_7", 1, 1);
    issue(0, 32'd9,   32'd3, {32'd3,  32'd0}, "b2b_9_div_3",   1, 0);
    drain();
    check("b2b_spacing", 64'(pulse_cyc[0] - prev_pulse_cyc[0]), 64'd36);

    // Reset 10 cycles after accept aborts the operation.
    issue(0, 32'd50, 32'd5, 64'h0, "abort_op", 0, 0);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_reset_tready", 64'(rdy_a[0] | rdy_b[0]), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_post_tready", 64'(rdy_a[0] & rdy_b[0]), 64'd1);
    check("abort_post_tdata", od[0], 64'h0);
    check("abort_post_tvalid", 64'(ov[0]), 64'd0);
    repeat (40) @(negedge clk);
    issue(0, 32'd6, 32'd4, {32'd1, 32'd2}, "after_abort_6_div_4", 1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
